// File: rtl/wb_mem_responder.sv
// Pipelined Wishbone B4 memory slave: fixed-latency responses, byte-select writes,
// forced stall from test control and bus errors for addresses outside the memory.
module wb_mem_responder #(
    parameter int AW      = 5,
    parameter int DW      = 32,
    parameter int LGMEM   = 4,
    parameter int LATENCY = 2,
    parameter int MAXOUT  = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_wb_cyc,
    input  logic                         i_wb_stb,
    input  logic                         i_wb_we,
    input  logic [AW-1:0]                i_wb_addr,
    input  logic [DW-1:0]                i_wb_data,
    input  logic [DW/8-1:0]              i_wb_sel,
    output logic                         o_wb_stall,
    output logic                         o_wb_ack,
    output logic [DW-1:0]                o_wb_data,
    output logic                         o_wb_err,
    input  logic                         i_stall_req,
    output logic [$clog2(MAXOUT+1)-1:0]  o_outstanding
);
    localparam int SW    = DW / 8;
    localparam int OW    = $clog2(MAXOUT + 1);
    localparam int DEPTH = 1 << LGMEM;

    logic [DW-1:0]      r_mem [DEPTH];
    logic [LATENCY-1:0] r_valid;
    logic [LATENCY-1:0] r_err;
    logic [DW-1:0]      r_data [LATENCY];
    logic [OW-1:0]      r_outstanding;

    logic               w_inRange;
    logic [LGMEM-1:0]   w_memAddr;
    logic               w_stall;
    logic               w_accept;
    logic               w_lastErr;
    logic               w_flush;
    logic [DW-1:0]      w_rdata;
    logic [DW-1:0]      w_stage0Data;

    generate
        if (LGMEM < AW) begin : g_rangeCheck
            assign w_inRange = (i_wb_addr[AW-1:LGMEM] == '0);
        end else begin : g_fullRange
            assign w_inRange = 1'b1;
        end
    endgenerate

    assign w_memAddr = i_wb_addr[LGMEM-1:0];
    assign w_stall   = i_stall_req || (r_outstanding == OW'(MAXOUT));
    assign w_accept  = i_wb_cyc && i_wb_stb && !w_stall;
    assign w_lastErr = r_valid[LATENCY-1] && r_err[LATENCY-1];

    // Dropping cyc abandons the burst, and an err ends it, so anything in flight is discarded.
    assign w_flush = !i_wb_cyc || w_lastErr;

    assign w_rdata      = r_mem[w_memAddr];
    assign w_stage0Data = (w_accept && !i_wb_we && w_inRange) ? w_rdata : '0;

    // Writes land at the accept edge, so a read issued on the next cycle sees the new bytes.
    always_ff @(posedge i_clk) begin
        if (w_accept && !w_flush && i_wb_we && w_inRange) begin
            for (int k = 0; k < SW; k++) begin
                if (i_wb_sel[k]) begin
                    r_mem[w_memAddr][8*k +: 8] <= i_wb_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid       <= '0;
            r_err         <= '0;
            r_outstanding <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_data[i] <= '0;
            end
        end else if (w_flush) begin
            r_valid       <= '0;
            r_err         <= '0;
            r_outstanding <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0] <= w_accept;
            r_err[0]   <= w_accept && !w_inRange;
            r_data[0]  <= w_stage0Data;
            for (int i = 1; i < LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_err[i]   <= r_err[i-1];
                r_data[i]  <= r_data[i-1];
            end
            r_outstanding <= r_outstanding + OW'(w_accept) - OW'(r_valid[LATENCY-1]);
        end
    end

    assign o_wb_stall    = w_stall;
    assign o_wb_ack      = i_wb_cyc && r_valid[LATENCY-1] && !r_err[LATENCY-1];
    assign o_wb_err      = i_wb_cyc && w_lastErr;
    assign o_wb_data     = r_data[LATENCY-1];
    assign o_outstanding = r_outstanding;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench for wb_mem_responder: a default instance (LATENCY=2, MAXOUT=4)
// and a throttled instance (LATENCY=3, MAXOUT=1) sharing clock and reset.
module tb_wb_mem_responder;

    logic        clk;
    logic        rst_n;

    logic        aCyc, aStb, aWe, aStallReq;
    logic [4:0]  aAddr;
    logic [31:0] aWData;
    logic [3:0]  aSel;
    logic        aStall, aAck, aErr;
    logic [31:0] aRData;
    logic [2:0]  aOut;

    logic        bCyc, bStb, bWe, bStallReq;
    logic [4:0]  bAddr;
    logic [31:0] bWData;
    logic [3:0]  bSel;
    logic        bStall, bAck, bErr;
    logic [31:0] bRData;
    logic [0:0]  bOut;

    int tests;
    int failures;

    typedef struct {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic        stallReq;
        logic        expAck;
        logic        expErr;
        logic        expStall;
        logic [31:0] expData;
        logic [2:0]  expOut;
    } vec_t;

    vec_t vecs[$];

    wb_mem_responder #(.AW(5), .DW(32), .LGMEM(4), .LATENCY(2), .MAXOUT(4)) dutA (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_wb_cyc(aCyc), .i_wb_stb(aStb), .i_wb_we(aWe), .i_wb_addr(aAddr),
        .i_wb_data(aWData), .i_wb_sel(aSel),
        .o_wb_stall(aStall), .o_wb_ack(aAck), .o_wb_data(aRData), .o_wb_err(aErr),
        .i_stall_req(aStallReq), .o_outstanding(aOut)
    );

    wb_mem_responder #(.AW(5), .DW(32), .LGMEM(4), .LATENCY(3), .MAXOUT(1)) dutB (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_wb_cyc(bCyc), .i_wb_stb(bStb), .i_wb_we(bWe), .i_wb_addr(bAddr),
        .i_wb_data(bWData), .i_wb_sel(bSel),
        .o_wb_stall(bStall), .o_wb_ack(bAck), .o_wb_data(bRData), .o_wb_err(bErr),
        .i_stall_req(bStallReq), .o_outstanding(bOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic cyc, input logic stb, input logic we,
                                 input logic [4:0] addr, input logic [31:0] data,
                                 input logic [3:0] sel, input logic stallReq);
        aCyc      = cyc;
        aStb      = stb;
        aWe       = we;
        aAddr     = addr;
        aWData    = data;
        aSel      = sel;
        aStallReq = stallReq;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic cyc, input logic stb, input logic we, input logic [4:0] addr,
                          input logic [31:0] data, input logic [3:0] sel, input logic stallReq,
                          input logic eAck, input logic eErr, input logic eStall,
                          input logic [31:0] eData, input logic [2:0] eOut);
        vec_t v;
        v.cyc = cyc; v.stb = stb; v.we = we; v.addr = addr; v.data = data; v.sel = sel;
        v.stallReq = stallReq; v.expAck = eAck; v.expErr = eErr; v.expStall = eStall;
        v.expData = eData; v.expOut = eOut;
        vecs.push_back(v);
    endtask

    initial begin
        int ackCnt, firstAck, lastAck, peakOut;
        int reqIdx, respIdx, pendCycle, lastAccept, modelOut, bErrSeen;
        logic [31:0] expResp;

        tests    = 0;
        failures = 0;
        rst_n    = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 4'h0, 1'b0);
        bCyc = 1'b0; bStb = 1'b0; bWe = 1'b0; bAddr = 5'd0; bWData = 32'd0; bSel = 4'hF;
        bStallReq = 1'b0;

        // Single write then read of word 3
        addVec(1,1,1,5'd3,32'hDEADBEEF,4'hF,0, 0,0,0,32'h0,3'd0);
        addVec(1,1,0,5'd3,32'h0,4'hF,0,        0,0,0,32'h0,3'd1);
        addVec(1,0,0,5'd0,32'h0,4'h0,0,        1,0,0,32'h0,3'd2);
        addVec(1,0,0,5'd0,32'h0,4'h0,0,        1,0,0,32'hDEADBEEF,3'd1);
        addVec(0,0,0,5'd0,32'h0,4'h0,0,        0,0,0,32'h0,3'd0);
        // Byte-select merge into word 5
        addVec(1,1,1,5'd5,32'hFFFFFFFF,4'hF,0, 0,0,0,32'h0,3'd0);
        addVec(1,1,1,5'd5,32'h11223344,4'h5,0, 0,0,0,32'h0,3'd1);
        addVec(1,1,0,5'd5,32'h0,4'hF,0,        1,0,0,32'h0,3'd2);
        addVec(1,0,0,5'd0,32'h0,4'h0,0,        1,0,0,32'h0,3'd2);
        addVec(1,0,0,5'd0,32'h0,4'h0,0,        1,0,0,32'hFF22FF44,3'd1);
        addVec(0,0,0,5'd0,32'h0,4'h0,0,        0,0,0,32'h0,3'd0);
        // Forced stall blocks a write; the following read shows memory unchanged
        addVec(1,1,1,5'd5,32'h0,4'hF,1,        0,0,1,32'h0,3'd0);
        addVec(1,1,0,5'd5,32'h0,4'hF,0,        0,0,0,32'h0,3'd0);
        addVec(1,0,0,5'd0,32'h0,4'h0,0,        0,0,0,32'h0,3'd1);
        addVec(1,0,0,5'd0,32'h0,4'h0,0,        1,0,0,32'hFF22FF44,3'd1);
        addVec(0,0,0,5'd0,32'h0,4'h0,0,        0,0,0,32'h0,3'd0);
        // Out-of-range read mid-burst: err, then pending read and err-cycle request dropped
        addVec(1,1,1,5'd1,32'hAAAA0001,4'hF,0, 0,0,0,32'h0,3'd0);
        addVec(1,1,1,5'd2,32'hBBBB0002,4'hF,0, 0,0,0,32'h0,3'd1);
        addVec(1,1,0,5'd1,32'h0,4'hF,0,        1,0,0,32'h0,3'd2);
        addVec(1,1,0,5'd2,32'h0,4'hF,0,        1,0,0,32'h0,3'd2);
        addVec(1,1,0,5'd16,32'h0,4'hF,0,       1,0,0,32'hAAAA0001,3'd2);
        addVec(1,1,0,5'd3,32'h0,4'hF,0,        1,0,0,32'hBBBB0002,3'd2);
        addVec(1,1,0,5'd4,32'h0,4'hF,0,        0,1,0,32'h0,3'd2);
        addVec(1,0,0,5'd0,32'h0,4'h0,0,        0,0,0,32'h0,3'd0);
        addVec(1,0,0,5'd0,32'h0,4'h0,0,        0,0,0,32'h0,3'd0);
        // Abandon a cycle with two reads in flight
        addVec(1,1,0,5'd1,32'h0,4'hF,0,        0,0,0,32'h0,3'd0);
        addVec(1,1,0,5'd2,32'h0,4'hF,0,        0,0,0,32'h0,3'd1);
        addVec(0,0,0,5'd0,32'h0,4'h0,0,        0,0,0,32'h0,3'd2);
        addVec(1,0,0,5'd0,32'h0,4'h0,0,        0,0,0,32'h0,3'd0);
        addVec(1,0,0,5'd0,32'h0,4'h0,0,        0,0,0,32'h0,3'd0);

        #13;
        checkOutput("reset_ack",   {31'd0, aAck},   32'd0);
        checkOutput("reset_err",   {31'd0, aErr},   32'd0);
        checkOutput("reset_data",  aRData,          32'd0);
        checkOutput("reset_out",   {29'd0, aOut},   32'd0);
        checkOutput("reset_stall", {31'd0, aStall}, 32'd0);
        checkOutput("reset_outB",  {31'd0, bOut},   32'd0);
        #9;
        rst_n = 1'b1;
        nextCycle();

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].cyc, vecs[i].stb, vecs[i].we, vecs[i].addr,
                          vecs[i].data, vecs[i].sel, vecs[i].stallReq);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_ack", i),   {31'd0, aAck},   {31'd0, vecs[i].expAck});
            checkOutput($sformatf("vec%0d_err", i),   {31'd0, aErr},   {31'd0, vecs[i].expErr});
            checkOutput($sformatf("vec%0d_stall", i), {31'd0, aStall}, {31'd0, vecs[i].expStall});
            checkOutput($sformatf("vec%0d_out", i),   {29'd0, aOut},   {29'd0, vecs[i].expOut});
            if (vecs[i].expAck) begin
                checkOutput($sformatf("vec%0d_data", i), aRData, vecs[i].expData);
            end
            nextCycle();
        end

        // Fill words 0..7, then an 8-read pipelined burst
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 5'(i), 32'hC0DE0000 + 32'(i), 4'hF, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 4'h0, 1'b0);
        nextCycle();
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 4'h0, 1'b0);
        nextCycle();

        ackCnt = 0; firstAck = -1; lastAck = -1; peakOut = 0;
        for (int c = 0; c < 12; c++) begin
            if (c < 8) applyStimulus(1'b1, 1'b1, 1'b0, 5'(c), 32'd0, 4'hF, 1'b0);
            else       applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 4'h0, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("burst_stall_c%0d", c), {31'd0, aStall}, 32'd0);
            if (int'(aOut) > peakOut) peakOut = int'(aOut);
            if (aAck) begin
                checkOutput($sformatf("burst_data%0d", ackCnt), aRData, 32'hC0DE0000 + 32'(ackCnt));
                if (firstAck < 0) firstAck = c;
                lastAck = c;
                ackCnt++;
            end
            nextCycle();
        end
        checkOutput("burst_ack_count", 32'(ackCnt), 32'd8);
        checkOutput("burst_first_ack", 32'(firstAck), 32'd2);
        checkOutput("burst_ack_span",  32'(lastAck - firstAck), 32'd7);
        checkOutput("burst_peak_out",  32'(peakOut), 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 4'h0, 1'b0);
        nextCycle();

        // Throttled instance: 3 writes then 3 reads, one request in flight at a time
        reqIdx = 0; respIdx = 0; pendCycle = -1; lastAccept = -1; modelOut = 0; bErrSeen = 0;
        for (int c = 0; c < 80 && respIdx < 6; c++) begin
            bCyc   = 1'b1;
            bStb   = (reqIdx < 6);
            bWe    = (reqIdx < 3);
            bAddr  = 5'(reqIdx % 3);
            bWData = 32'h5A5A0000 + 32'(reqIdx % 3);
            @(negedge clk);
            checkOutput($sformatf("B_out_c%0d", c),   {31'd0, bOut},   32'(modelOut));
            checkOutput($sformatf("B_stall_c%0d", c), {31'd0, bStall}, 32'(modelOut == 1));
            if (bErr) bErrSeen++;
            if (bAck) begin
                expResp = (respIdx < 3) ? 32'd0 : 32'h5A5A0000 + 32'(respIdx - 3);
                checkOutput($sformatf("B_resp%0d_data", respIdx), bRData, expResp);
                checkOutput($sformatf("B_resp%0d_lat", respIdx), 32'(c - pendCycle), 32'd3);
                respIdx++;
                modelOut = 0;
                pendCycle = -1;
            end else if (bStb && !bStall) begin
                if (lastAccept >= 0) begin
                    checkOutput($sformatf("B_gap_req%0d", reqIdx), 32'(c - lastAccept >= 3), 32'd1);
                end
                lastAccept = c;
                pendCycle  = c;
                reqIdx++;
                modelOut = 1;
            end
            nextCycle();
        end
        checkOutput("B_resp_count", 32'(respIdx), 32'd6);
        checkOutput("B_err_seen",   32'(bErrSeen), 32'd0);
        bCyc = 1'b0;
        bStb = 1'b0;
        nextCycle();

        // Reset pulse mid-burst: outputs clear immediately, memory survives
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd1, 32'd0, 4'hF, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd2, 32'd0, 4'hF, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 4'h0, 1'b0);
        #1;
        checkOutput("prereset_ack",  {31'd0, aAck}, 32'd1);
        checkOutput("prereset_data", aRData, 32'hC0DE0001);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_ack",  {31'd0, aAck}, 32'd0);
        checkOutput("midreset_err",  {31'd0, aErr}, 32'd0);
        checkOutput("midreset_data", aRData, 32'd0);
        checkOutput("midreset_out",  {29'd0, aOut}, 32'd0);
        #1;
        rst_n = 1'b1;
        nextCycle();
        @(negedge clk);
        checkOutput("postreset_ack", {31'd0, aAck}, 32'd0);
        checkOutput("postreset_out", {29'd0, aOut}, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd2, 32'd0, 4'hF, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 4'h0, 1'b0);
        nextCycle();
        @(negedge clk);
        checkOutput("postreset_read_ack",  {31'd0, aAck}, 32'd1);
        checkOutput("postreset_read_data", aRData, 32'hC0DE0002);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 4'h0, 1'b0);
        nextCycle();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
